alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: hands one instruction at a time to an external combinational
// 8-bit ALU, captures its result into a valid/ready output register and an
// accumulator, and counts completed result handoffs.
module alu_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_opcode,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_use_acc,
  input  logic             acc_clear,
  output logic [1:0]       alu_opcode,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  input  logic [7:0]       alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             res_zero,
  output logic [7:0]       acc,
  output logic [CNT_W-1:0] op_count,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       alu_opcode_q, alu_opcode_d;
  logic [7:0]       alu_a_q, alu_a_d;
  logic [7:0]       alu_b_q, alu_b_d;
  logic [7:0]       res_data_q, res_data_d;
  logic             res_valid_q, res_valid_d;
  logic [7:0]       acc_q, acc_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             accept;

  // Next-state and register-update logic; an accept can happen in IDLE or,
  // back-to-back, in the same edge that completes a DONE handoff.
  always_comb begin
    state_d      = state_q;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    res_data_d   = res_data_q;
    res_valid_d  = res_valid_q;
    acc_d        = acc_q;
    op_count_d   = op_count_q;
    in_ready     = 1'b0;
    accept       = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (acc_clear) acc_d = 8'h00;
      end
      EXEC: begin
        // The capture owns the accumulator this edge; acc_clear is ignored.
        res_data_d  = alu_out;
        acc_d       = alu_out;
        res_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        in_ready = res_ready;
        if (acc_clear) acc_d = 8'h00;
        if (res_ready) begin
          res_valid_d = 1'b0;
          op_count_d  = op_count_q + 1'b1;
          accept      = in_valid;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Operand A from the accumulator uses the pre-update value, which in the
    // back-to-back case is the result just handed off.
    if (accept) begin
      alu_opcode_d = in_opcode;
      alu_a_d      = in_use_acc ? acc_q : in_a;
      alu_b_d      = in_b;
      state_d      = EXEC;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      alu_opcode_q <= 2'b00;
      alu_a_q      <= 8'h00;
      alu_b_q      <= 8'h00;
      res_data_q   <= 8'h00;
      res_valid_q  <= 1'b0;
      acc_q        <= 8'h00;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      res_data_q   <= res_data_d;
      res_valid_q  <= res_valid_d;
      acc_q        <= acc_d;
      op_count_q   <= op_count_d;
    end
  end

  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign res_data   = res_data_q;
  assign res_valid  = res_valid_q;
  assign res_zero   = (res_data_q == 8'h00);
  assign acc        = acc_q;
  assign op_count   = op_count_q;
  assign busy       = (state_q != IDLE);

endmodule
